// File: rtl/adder_pkg.sv
// adder_pkg: shared state and mode encodings for the serial chunk adder
package adder_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/fa_chunk.sv
// fa_chunk: CHUNK-bit combinational ripple adder built from single-bit full adders
module fa_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);
  logic [CHUNK:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end
  assign co       = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];
endmodule

// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder: multi-cycle two's-complement add/sub, CHUNK bits per clock
module serial_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int N = WIDTH / CHUNK;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_r, b_r, acc, acc_next;
  logic carry, co, c_msb;
  logic [CHUNK-1:0] s;
  fa_chunk #(.CHUNK(CHUNK)) u_fa (
    .x(a_r[CHUNK-1:0]),
    .y(b_r[CHUNK-1:0]),
    .ci(carry),
    .s(s),
    .co(co),
    .c_msb_in(c_msb)
  );
  // each new chunk enters at the top while earlier chunks shift down into place
  always_comb acc_next = (acc >> CHUNK) | (WIDTH'(s) << (WIDTH - CHUNK));
  // FSM: latch operands on accept, ripple one chunk per cycle, publish on the last chunk
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      carry    <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        if (start) begin
          a_r   <= a;
          b_r   <= sub == MODE_SUB ? ~b : b;
          carry <= sub == MODE_SUB ? ~cin : cin;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= ST_RUN;
        end
      end else begin
        a_r   <= a_r >> CHUNK;
        b_r   <= b_r >> CHUNK;
        acc   <= acc_next;
        carry <= co;
        cnt   <= cnt == LAST ? cnt : cnt + CW'(1);
        if (cnt == LAST) begin
          sum      <= acc_next;
          cout     <= co;
          overflow <= co ^ c_msb;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_chunk_adder.sv
// tb_serial_chunk_adder: four parameter sets driven in lockstep against an arithmetic model
module tb_serial_chunk_adder;
  logic clk = 1'b0;
  logic rst, start, sub, cin;
  logic [31:0] a_bus, b_bus;
  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act !== exp) $display("FAIL %s got %0h want %0h", name, act, exp);
    else passed++;
  endtask

  // reference result from plain integer arithmetic on w-bit operands
  function automatic void model(input int w, input logic [31:0] x, input logic [31:0] y,
                                input logic c, input logic s,
                                output logic [31:0] r, output logic co, output logic ov);
    longint m, h, ua, ub, sa, sb, ci, t;
    m  = (64'sd1 <<< w) - 1;
    h  = 64'sd1 <<< (w - 1);
    ua = longint'(x) & m;
    ub = longint'(y) & m;
    sa = (ua ^ h) - h;
    sb = (ub ^ h) - h;
    ci = c ? 64'sd1 : 64'sd0;
    if (s) begin
      r  = 32'((ua - ub - ci) & m);
      co = ua >= ub + ci;
      t  = sa - sb - ci;
    end else begin
      r  = 32'((ua + ub + ci) & m);
      co = ua + ub + ci > m;
      t  = sa + sb + ci;
    end
    ov = t < -h || t >= h;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : gi
    localparam int W = g == 0 ? 16 : (g == 3 ? 32 : 8);
    localparam int C = g == 0 ? 4 : (g == 1 ? 8 : (g == 2 ? 1 : 4));
    localparam int N = W / C;
    logic busy, done, cout, ovf;
    logic [W-1:0] sum;
    logic m_busy = 1'b0, m_done = 1'b0, m_cout = 1'b0, m_ovf = 1'b0, p_cout, p_ovf;
    logic [W-1:0] m_sum = '0;
    logic [31:0] p_sum;
    int rem = 0;
    serial_chunk_adder #(.WIDTH(W), .CHUNK(C)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub),
      .a(a_bus[W-1:0]), .b(b_bus[W-1:0]), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(ovf)
    );
    always @(posedge clk) begin
      m_done = 1'b0;
      if (rst) begin
        m_busy = 1'b0; rem = 0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
      end else if (!m_busy) begin
        if (start) begin
          model(W, a_bus, b_bus, cin, sub, p_sum, p_cout, p_ovf);
          m_busy = 1'b1;
          rem = N;
        end
      end else begin
        rem--;
        if (rem == 0) begin
          m_busy = 1'b0; m_done = 1'b1;
          m_sum = p_sum[W-1:0]; m_cout = p_cout; m_ovf = p_ovf;
        end
      end
    end
    always @(negedge clk) begin
      chk($sformatf("busy[%0d]", g), 64'(busy), 64'(m_busy));
      chk($sformatf("done[%0d]", g), 64'(done), 64'(m_done));
      chk($sformatf("sum[%0d]", g), 64'(sum), 64'(m_sum));
      chk($sformatf("cout[%0d]", g), 64'(cout), 64'(m_cout));
      chk($sformatf("ovf[%0d]", g), 64'(ovf), 64'(m_ovf));
    end
  end

  task automatic op(input logic [31:0] x, input logic [31:0] y, input logic c, input logic s);
    @(negedge clk);
    a_bus = x; b_bus = y; cin = c; sub = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a_bus = $urandom; b_bus = $urandom; cin = 1'($urandom); sub = 1'($urandom);
    repeat (9) @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [15:0] s, input logic co, input logic ov);
    chk({name, "_sum"}, 64'(gi[0].sum), 64'(s));
    chk({name, "_cout"}, 64'(gi[0].cout), 64'(co));
    chk({name, "_ovf"}, 64'(gi[0].ovf), 64'(ov));
  endtask

  initial begin
    logic [31:0] r;
    logic co, ov;
    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a_bus = '0; b_bus = '0;
    model(16, 32'h1234, 32'h0FCD, 1'b0, 1'b0, r, co, ov);
    chk("model_add", {r, 7'd0, co, 7'd0, ov}, {32'h2201, 16'h0000});
    model(16, 32'h7FFF, 32'h0001, 1'b0, 1'b0, r, co, ov);
    chk("model_ovf", {r, 7'd0, co, 7'd0, ov}, {32'h8000, 16'h0001});
    model(16, 32'h8000, 32'h0001, 1'b0, 1'b1, r, co, ov);
    chk("model_sub", {r, 7'd0, co, 7'd0, ov}, {32'h7FFF, 16'h0101});
    model(16, 32'hFFFF, 32'h0000, 1'b1, 1'b0, r, co, ov);
    chk("model_ripple", {r, 7'd0, co, 7'd0, ov}, {32'h0000, 16'h0100});
    repeat (2) @(negedge clk);
    lit("reset", 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    op(32'h1234, 32'h0FCD, 1'b0, 1'b0);
    lit("add", 16'h2201, 1'b0, 1'b0);
    op(32'hFFFF, 32'h0000, 1'b1, 1'b0);
    lit("ripple", 16'h0000, 1'b1, 1'b0);
    op(32'h7FFF, 32'h0001, 1'b0, 1'b0);
    lit("ovf_add", 16'h8000, 1'b0, 1'b1);
    op(32'h8000, 32'h0001, 1'b0, 1'b1);
    lit("ovf_sub", 16'h7FFF, 1'b1, 1'b1);
    @(negedge clk);
    a_bus = $urandom; b_bus = $urandom; start = 1'b1;
    repeat (12) @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_bus = $urandom; b_bus = $urandom; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    repeat (10) @(negedge clk);
    @(negedge clk);
    a_bus = $urandom; b_bus = $urandom; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(gi[0].busy), 64'd0);
    chk("abort_done", 64'(gi[0].done), 64'd0);
    chk("abort_sum", 64'(gi[0].sum), 64'd0);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", 64'(gi[0].busy), 64'd0);
    op(32'h0000_0003, 32'h0000_0004, 1'b1, 1'b0);
    lit("after_abort", 16'h0008, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      op($urandom, $urandom, 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
